// File: rtl/csr_arbiter.sv
// Two-master round-robin arbiter onto a shared CSR bus, with grant lock,
// hold timeout and one mandatory dead cycle between owners.
module csr_arbiter #(
    parameter logic [7:0] TIMEOUT    = 8'd200,
    parameter logic       PRIO_RESET = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       m0_req,
    input  logic       m0_lock,
    input  logic [4:0] m0_a,
    input  logic       m0_we,
    input  logic [7:0] m0_do,
    output logic       m0_gnt,
    output logic [7:0] m0_di,
    input  logic       m1_req,
    input  logic       m1_lock,
    input  logic [4:0] m1_a,
    input  logic       m1_we,
    input  logic [7:0] m1_do,
    output logic       m1_gnt,
    output logic [7:0] m1_di,
    output logic [4:0] csr_a,
    output logic       csr_we,
    output logic [7:0] csr_do,
    input  logic [7:0] csr_di,
    output logic       timeout_irq,
    output logic       owner
);
    typedef enum logic [1:0] {IDLE, GNT0, GNT1, HOLDOFF} state_t;

    state_t     state, state_nxt;
    logic [7:0] cnt;
    logic [1:0] blk;
    logic [1:0] req, gnt, elig;
    logic       cur, hold, tmo, in_gnt;

    assign req    = {m1_req, m0_req};
    assign gnt    = {state == GNT1, state == GNT0};
    assign in_gnt = (state == GNT0) || (state == GNT1);
    assign cur    = (state == GNT1);
    assign elig   = req & ~blk;
    assign hold   = cur ? (m1_req | m1_lock) : (m0_req | m0_lock);
    // Timeout fires in the TIMEOUT-th granted cycle, overriding lock.
    assign tmo    = (TIMEOUT != 8'd0) && in_gnt && (cnt == TIMEOUT - 8'd1);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (elig == 2'b11)
                    state_nxt = owner ? GNT0 : GNT1;
                else if (elig[0])
                    state_nxt = GNT0;
                else if (elig[1])
                    state_nxt = GNT1;
            end
            GNT0, GNT1: if (tmo || !hold) state_nxt = HOLDOFF;
            HOLDOFF:    state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            blk         <= 2'b00;
            owner       <= ~PRIO_RESET;
            timeout_irq <= 1'b0;
        end else begin
            state       <= state_nxt;
            timeout_irq <= tmo;
            if (state == IDLE && state_nxt != IDLE) begin
                cnt   <= 8'd0;
                owner <= (state_nxt == GNT1);
            end else if (in_gnt && cnt != 8'hff) begin
                cnt <= cnt + 8'd1;
            end
            for (int i = 0; i < 2; i++) begin
                if (tmo && cur == i[0])
                    blk[i] <= 1'b1;
                else if (!req[i])
                    blk[i] <= 1'b0;
            end
        end
    end

    // Bus mux is driven straight from the registered state, so reset clears it at once.
    assign m0_gnt = gnt[0];
    assign m1_gnt = gnt[1];
    assign csr_a  = gnt[0] ? m0_a  : gnt[1] ? m1_a  : 5'd0;
    assign csr_do = gnt[0] ? m0_do : gnt[1] ? m1_do : 8'd0;
    assign csr_we = (m0_we & gnt[0]) | (m1_we & gnt[1]);
    assign m0_di  = gnt[0] ? csr_di : 8'h00;
    assign m1_di  = gnt[1] ? csr_di : 8'h00;
endmodule

// File: tb/tb_csr_arbiter.sv
// Bench for csr_arbiter: directed scenarios with literal expectations plus a
// holder/dead-cycle model checked every cycle under random traffic.
module tb_csr_arbiter;
    localparam logic [7:0] TO = 8'd4;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       m0_req = 0, m0_lock = 0, m0_we = 0, m1_req = 0, m1_lock = 0, m1_we = 0;
    logic [4:0] m0_a = 0, m1_a = 0;
    logic [7:0] m0_do = 0, m1_do = 0, csr_di = 0;
    logic       m0_gnt, m1_gnt, csr_we, timeout_irq, owner;
    logic [7:0] m0_di, m1_di, csr_do;
    logic [4:0] csr_a;

    csr_arbiter #(.TIMEOUT(TO), .PRIO_RESET(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_a(m0_a), .m0_we(m0_we), .m0_do(m0_do),
        .m0_gnt(m0_gnt), .m0_di(m0_di),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_a(m1_a), .m1_we(m1_we), .m1_do(m1_do),
        .m1_gnt(m1_gnt), .m1_di(m1_di),
        .csr_a(csr_a), .csr_we(csr_we), .csr_do(csr_do), .csr_di(csr_di),
        .timeout_irq(timeout_irq), .owner(owner)
    );

    always #5 clk = ~clk;

    int vecs = 0, errs = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: who holds the bus, forced no-grant cycles left before arbitration,
    // cycles held so far, last winner, per-master block after timeout.
    int         holder, dead, held, last;
    logic [1:0] blk;
    logic       irq_e;

    always @(posedge clk or negedge rst_n) begin : model
        int h, d, n, l;
        logic [1:0] b, rq, lk, el, set;
        logic ir;
        if (!rst_n) begin
            holder <= -1; dead <= 0; held <= 0; last <= 1; blk <= 2'b00; irq_e <= 1'b0;
        end else begin
            h = holder; d = dead; n = held; l = last; b = blk; ir = 1'b0; set = 2'b00;
            rq = {m1_req, m0_req};
            lk = {m1_lock, m0_lock};
            if (h >= 0) begin
                n = n + 1;
                if (n == int'(TO)) begin
                    ir = 1'b1; set[h[0]] = 1'b1; h = -1; d = 1;
                end else if (!rq[h[0]] && !lk[h[0]]) begin
                    h = -1; d = 1;
                end
            end else if (d > 0) begin
                d = d - 1;
            end else begin
                el = rq & ~blk;
                if (el == 2'b11)  h = 1 - l;
                else if (el[0])   h = 0;
                else if (el[1])   h = 1;
                if (h >= 0) begin n = 0; l = h; end
            end
            for (int i = 0; i < 2; i++)
                if (set[i]) b[i] = 1'b1;
                else if (!rq[i]) b[i] = 1'b0;
            holder <= h; dead <= d; held <= n; last <= l; blk <= b; irq_e <= ir;
        end
    end

    always @(negedge clk) begin : compare
        logic [4:0] ea;
        logic [7:0] ed;
        logic       ew;
        if (rst_n) begin
            ea = (holder == 0) ? m0_a  : (holder == 1) ? m1_a  : 5'd0;
            ed = (holder == 0) ? m0_do : (holder == 1) ? m1_do : 8'd0;
            ew = (holder == 0) ? m0_we : (holder == 1) ? m1_we : 1'b0;
            chk("m0_gnt", 32'(m0_gnt), 32'(holder == 0));
            chk("m1_gnt", 32'(m1_gnt), 32'(holder == 1));
            chk("owner", 32'(owner), 32'(last));
            chk("timeout_irq", 32'(timeout_irq), 32'(irq_e));
            chk("csr_a", 32'(csr_a), 32'(ea));
            chk("csr_do", 32'(csr_do), 32'(ed));
            chk("csr_we", 32'(csr_we), 32'(ew));
            chk("m0_di", 32'(m0_di), (holder == 0) ? 32'(csr_di) : 32'd0);
            chk("m1_di", 32'(m1_di), (holder == 1) ? 32'(csr_di) : 32'd0);
            chk("one_gnt", 32'(m0_gnt & m1_gnt), 32'd0);
            chk("we_no_gnt", 32'(csr_we & ~(m0_gnt | m1_gnt)), 32'd0);
        end
    end

    task automatic clear_inputs();
        m0_req = 0; m0_lock = 0; m0_we = 0; m0_a = 0; m0_do = 0;
        m1_req = 0; m1_lock = 0; m1_we = 0; m1_a = 0; m1_do = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    int ng, ni;

    initial begin
        do_reset();
        chk("rst_gnt", 32'({m1_gnt, m0_gnt}), 32'd0);
        chk("rst_owner", 32'(owner), 32'd1);
        chk("rst_irq", 32'(timeout_irq), 32'd0);

        // Single request: one-cycle grant latency, bus follows master 0.
        m0_req = 1; m0_a = 5'h10; m0_we = 1; m0_do = 8'h5a; csr_di = 8'h3c;
        tick();
        chk("a_m0_gnt", 32'(m0_gnt), 32'd1);
        chk("a_owner", 32'(owner), 32'd0);
        chk("a_csr_a", 32'(csr_a), 32'h10);
        chk("a_csr_we", 32'(csr_we), 32'd1);
        chk("a_csr_do", 32'(csr_do), 32'h5a);
        chk("a_m0_di", 32'(m0_di), 32'h3c);
        chk("a_m1_di", 32'(m1_di), 32'h00);
        m0_req = 0; m0_we = 0;
        tick();
        chk("a_release", 32'(m0_gnt), 32'd0);

        // Simultaneous requests after reset: m0 first, m1 two cycles after release.
        do_reset();
        m0_req = 1; m1_req = 1;
        tick();
        chk("b_m0_first", 32'({m1_gnt, m0_gnt}), 32'b01);
        m0_req = 0;
        tick();
        chk("b_holdoff", 32'({m1_gnt, m0_gnt}), 32'b00);
        tick();
        chk("b_idle", 32'({m1_gnt, m0_gnt}), 32'b00);
        tick();
        chk("b_m1_gnt", 32'({m1_gnt, m0_gnt}), 32'b10);

        // Lock keeps m1 while its req is low; dropping lock hands over to m0.
        m1_lock = 1; m1_req = 0;
        tick();
        chk("c_locked", 32'(m1_gnt), 32'd1);
        m1_lock = 0; m0_req = 1;
        tick();
        chk("c_drop", 32'({m1_gnt, m0_gnt}), 32'b00);
        tick();
        chk("c_dead", 32'({m1_gnt, m0_gnt}), 32'b00);
        tick();
        chk("c_m0_gnt", 32'({m1_gnt, m0_gnt}), 32'b01);
        m0_req = 0;
        repeat (2) tick();

        // Timeout: req+lock held, grant limited to TO cycles, then blocked.
        m0_req = 1; m0_lock = 1;
        ng = 0; ni = 0;
        repeat (10) begin
            tick();
            ng += int'(m0_gnt);
            ni += int'(timeout_irq);
        end
        chk("d_gnt_cycles", 32'(ng), 32'd4);
        chk("d_irq_pulses", 32'(ni), 32'd1);
        chk("d_blocked", 32'(m0_gnt), 32'd0);
        m0_req = 0; m0_lock = 0;
        tick();
        m0_req = 1; m0_we = 1; m0_a = 5'h03; m0_do = 8'h77;
        tick();
        chk("d_regrant", 32'(m0_gnt), 32'd1);

        // Reset mid-write clears the bus asynchronously.
        chk("e_we_before", 32'(csr_we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("e_we_async", 32'(csr_we), 32'd0);
        chk("e_gnt_async", 32'({m1_gnt, m0_gnt}), 32'd0);
        chk("e_a_async", 32'(csr_a), 32'd0);
        repeat (2) tick();
        chk("e_we_held", 32'(csr_we), 32'd0);
        clear_inputs();
        rst_n = 1'b1;
        m1_req = 1;
        tick();
        chk("e_first_gnt", 32'(m1_gnt), 32'd1);

        for (int k = 0; k < 10000; k++) begin
            m0_req  = ($urandom_range(0, 9) < 6);
            m1_req  = ($urandom_range(0, 9) < 6);
            m0_lock = ($urandom_range(0, 9) < 2);
            m1_lock = ($urandom_range(0, 9) < 2);
            m0_we   = $urandom_range(0, 1) == 1;
            m1_we   = $urandom_range(0, 1) == 1;
            m0_a    = 5'($urandom);
            m1_a    = 5'($urandom);
            m0_do   = 8'($urandom);
            m1_do   = 8'($urandom);
            csr_di  = 8'($urandom);
            tick();
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/csr_arbiter.md
CSR_ARBITER -- requirements
Module: csr_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 8'd200, maximum number of cycles one master may hold a grant; 0 disables the timeout.
REQ-002 Parameter PRIO_RESET, default 1'b0, the master that wins the first simultaneous request after reset.
REQ-003 The clock is clk, a single clock domain; reset is asynchronous and active-low, named rst_n.
REQ-004 Ports, in order: clk in 1 clock; rst_n in 1 asynchronous active-low reset.
REQ-005 Master 0 ports (I2C slave): m0_req in 1; m0_lock in 1 (hold grant); m0_a in 5; m0_we in 1; m0_do in 8 (write data).
REQ-006 Master 0 outputs: m0_gnt out 1; m0_di out 8 (read data).
REQ-007 Master 1 has the identical port set: m1_req, m1_lock, m1_a, m1_we, m1_do, m1_gnt, m1_di.
REQ-008 Register bus: csr_a out 5; csr_we out 1; csr_do out 8 (to registers); csr_di in 8 (OR-combined register read data).
REQ-009 Status outputs: timeout_irq out 1 (single-cycle pulse); owner out 1 (last granted master).

Function
REQ-010 The FSM has exactly the states IDLE, GNT0, GNT1 and HOLDOFF.
REQ-011 IDLE: if only mX_req is high, the next state is GNTX; if both are high, the master not equal to owner wins (round-robin); if neither is high, stay in IDLE.
REQ-012 Grant latency: a req sampled high in IDLE gives a registered mX_gnt on the next cycle; the minimum latency is 1 cycle.
REQ-013 GNTX: mX_gnt=1, the other master's gnt=0, owner<=X, and the state is held while mX_req=1.
REQ-014 When mX_req=0 in GNTX, the next state is HOLDOFF; mX_gnt drops in that same registered update.
REQ-015 HOLDOFF lasts exactly 1 cycle with no grant and csr_we=0, then goes to IDLE; this guarantees one dead cycle between owners.
REQ-016 mX_lock=1 in GNTX keeps the grant even if mX_req drops; the grant releases on the first cycle with req=0 and lock=0.
REQ-017 Bus mux while the FSM is in GNTX: csr_a=mX_a; csr_do=mX_do; csr_we=mX_we & mX_gnt.
REQ-018 Bus outputs with no grant: csr_a=0, csr_do=0, csr_we=0.
REQ-019 mX_di = csr_di when mX_gnt=1, else 8'h00; reads are combinational, with zero added latency.
REQ-020 The hold counter is 8 bits; it clears on entry to GNTX and increments each cycle in GNTX, saturating at 8'hff.
REQ-021 With TIMEOUT!=0, counter==TIMEOUT-1 in GNTX forces HOLDOFF regardless of lock, pulses timeout_irq for 1 cycle, and sets the internal flag blockX.
REQ-022 While blockX=1, mX_req is ignored in IDLE; blockX clears on the first cycle mX_req=0.
REQ-023 A master's req held continuously through HOLDOFF is eligible again in IDLE only via round-robin (REQ-011).
REQ-024 Simultaneous release and new request from the other master: HOLDOFF, then IDLE, then grant (2 cycles from release to the other gnt).
REQ-025 At most one gnt is high in any cycle, and csr_we is never high outside GNT0/GNT1.

Reset
REQ-026 rst_n=0 asynchronously forces: state=IDLE, m0_gnt=m1_gnt=0, csr_we=0, csr_a=0, csr_do=0.
REQ-027 rst_n=0 also forces: timeout_irq=0, counter=0, block0=block1=0, owner=~PRIO_RESET.
REQ-028 Reset asserted mid-grant aborts the transfer immediately; no csr_we pulse is issued after rst_n falls.
REQ-029 Deassertion of rst_n is synchronised externally; the first grant is possible 1 cycle after rst_n rises.

Verification
REQ-030 After reset, m0_req=1 alone -> cycle+1: m0_gnt=1, owner=0; m0_a=5'h10, m0_we=1, m0_do=8'h5a -> csr_a=5'h10, csr_we=1, csr_do=8'h5a.
REQ-031 m0_req and m1_req rise together after reset (PRIO_RESET=0) -> m0 granted; after m0 releases -> HOLDOFF, then m1_gnt=1 two cycles after release.
REQ-032 m1 granted with m1_lock=1 and m1_req pulsed low -> m1_gnt stays 1; dropping lock drops gnt next cycle, with one dead cycle before m0_gnt.
REQ-033 TIMEOUT=8'd4, m0 holds req+lock -> m0_gnt high exactly 4 cycles; timeout_irq pulses 1 cycle; m0 is re-granted only after its req drops and rises again.
REQ-034 rst_n driven low mid-write with csr_we=1 -> csr_we, m0_gnt and m1_gnt are 0 the same cycle (async), with no further writes.
REQ-035 Random req/lock/we stimulus for 10k cycles -> checker asserts REQ-025 and REQ-015 every cycle, and m0_di/m1_di=8'h00 when not granted.
